// File: rtl/mux_nway_arb.sv
// Registered N-way channel selector with valid/ready handshake on every channel.
// Fixed mode picks sel_i; round-robin mode scans from a rotating pointer.
module mux_nway_arb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned WAYS  = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WAYS*WIDTH-1:0] data_i,
    input  logic [WAYS-1:0]       valid_i,
    output logic [WAYS-1:0]       ready_o,
    input  logic                  mode_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [SEL_W-1:0]      grant_o
);

    if (SEL_W != $clog2(WAYS)) begin : g_sel_w_check
        $error("SEL_W must equal clog2(WAYS)");
    end

    localparam logic [SEL_W:0]   WaysW   = (SEL_W + 1)'(WAYS);
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(WAYS - 1);

    logic [WIDTH-1:0] chan [WAYS];

    for (genvar k = 0; k < WAYS; k++) begin : g_chan
        assign chan[k] = data_i[k*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             cand_found;
    logic [SEL_W-1:0] cand_idx;
    logic [SEL_W:0]   scan_idx;

    assign load_en = !valid_q || ready_i;

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_idx   = '0;
        if (!mode_i) begin
            if (({1'b0, sel_i} < WaysW) && valid_i[sel_i]) begin
                cand_found = 1'b1;
                cand_idx   = sel_i;
            end
        end else begin
            // Extra index bit keeps ptr+offset exact before the modulo fold.
            for (int unsigned i = 0; i < WAYS; i++) begin
                scan_idx = {1'b0, ptr_q} + (SEL_W + 1)'(i);
                if (scan_idx >= WaysW) begin
                    scan_idx = scan_idx - WaysW;
                end
                if (!cand_found && valid_i[scan_idx[SEL_W-1:0]]) begin
                    cand_found = 1'b1;
                    cand_idx   = scan_idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        ready_o = '0;
        data_d  = data_q;
        valid_d = valid_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (cand_found) begin
                // No handshake is offered while reset is held, so no beat is lost.
                if (!rst_i) begin
                    ready_o[cand_idx] = 1'b1;
                end
                data_d  = chan[cand_idx];
                grant_d = cand_idx;
                valid_d = 1'b1;
                if (mode_i) begin
                    ptr_d = (cand_idx == LastIdx) ? '0 : cand_idx + SEL_W'(1);
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_mux_nway_arb.sv
// Bench for mux_nway_arb: an 8-way and a 5-way instance checked against a
// cycle-level reference model plus a beat scoreboard.
module tb_mux_nway_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0]  ch8 [8];
    logic [127:0] d8_data;
    logic [7:0]   v8, r8;
    logic         mode8, rdy8, vo8;
    logic [2:0]   sel8, g8;
    logic [15:0]  do8;

    logic [15:0]  ch5 [5];
    logic [79:0]  d5_data;
    logic [4:0]   v5, r5;
    logic         mode5, rdy5, vo5;
    logic [2:0]   sel5, g5;
    logic [15:0]  do5;

    always_comb begin
        d8_data = '0;
        for (int k = 0; k < 8; k++) d8_data[k*16 +: 16] = ch8[k];
    end
    always_comb begin
        d5_data = '0;
        for (int k = 0; k < 5; k++) d5_data[k*16 +: 16] = ch5[k];
    end

    mux_nway_arb #(.WIDTH(16), .WAYS(8), .SEL_W(3)) dut8 (
        .clk_i(clk), .rst_i(rst), .data_i(d8_data), .valid_i(v8), .ready_o(r8),
        .mode_i(mode8), .sel_i(sel8), .data_o(do8), .valid_o(vo8), .ready_i(rdy8),
        .grant_o(g8)
    );

    mux_nway_arb #(.WIDTH(16), .WAYS(5), .SEL_W(3)) dut5 (
        .clk_i(clk), .rst_i(rst), .data_i(d5_data), .valid_i(v5), .ready_o(r5),
        .mode_i(mode5), .sel_i(sel5), .data_o(do5), .valid_o(vo5), .ready_i(rdy5),
        .grant_o(g5)
    );

    int passes = 0;
    int checks = 0;
    int seq = 0;

    // Reference model state
    bit          m8_v = 0, m5_v = 0;
    logic [15:0] m8_d = '0, m5_d = '0;
    int          m8_g = 0, m5_g = 0, p8 = 0, p5 = 0;

    function automatic int pick(int ways, logic [7:0] v, bit mode, int sel, int ptr);
        if (!mode) return (sel < ways && v[sel]) ? sel : -1;
        for (int off = 0; off < ways; off++)
            if (v[(ptr + off) % ways]) return (ptr + off) % ways;
        return -1;
    endfunction

    function automatic logic [7:0] exp_rdy(int ways, logic [7:0] v, bit mode, int sel,
                                           int ptr, bit mv, bit rdy);
        int c = pick(ways, v, mode, sel, ptr);
        if (rst || (mv && !rdy) || c < 0) return '0;
        return 8'(1 << c);
    endfunction

    task automatic tick8();
        int c;
        bit ld;
        c  = pick(8, v8, mode8, int'(sel8), p8);
        ld = !m8_v || rdy8;
        @(posedge clk);
        if (rst) begin
            m8_v = 0; m8_d = '0; m8_g = 0; p8 = 0;
        end else if (ld && c >= 0) begin
            m8_v = 1; m8_d = ch8[c]; m8_g = c;
            if (mode8) p8 = (c + 1) % 8;
        end else if (ld) begin
            m8_v = 0;
        end
        @(negedge clk);
    endtask

    task automatic tick5();
        int c;
        bit ld;
        c  = pick(5, {3'b000, v5}, mode5, int'(sel5), p5);
        ld = !m5_v || rdy5;
        @(posedge clk);
        if (rst) begin
            m5_v = 0; m5_d = '0; m5_g = 0; p5 = 0;
        end else if (ld && c >= 0) begin
            m5_v = 1; m5_d = ch5[c]; m5_g = c;
            if (mode5) p5 = (c + 1) % 5;
        end else if (ld) begin
            m5_v = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m8_v = 0; m8_d = '0; m8_g = 0; p8 = 0;
        m5_v = 0; m5_d = '0; m5_g = 0; p5 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode8 = 1'b1; sel8 = '0; rdy8 = 1'b1; v8 = '1;
        for (int k = 0; k < 8; k++) ch8[k] = 16'(16'h1000 + k);
        mode5 = 1'b1; sel5 = '0; rdy5 = 1'b1; v5 = '0;
        for (int k = 0; k < 5; k++) ch5[k] = 16'(16'h5000 + k);
        repeat (2) begin
            #1;
            checks++; if (r8 !== 8'h00) $display("FAIL reset_ready: got %b want 00000000", r8); else passes++;
            tick8();
            checks++;
            if ({vo8, do8, g8} !== {1'b0, 16'h0000, 3'd0})
                $display("FAIL reset_out: got v=%b d=%h g=%0d want v=0 d=0000 g=0", vo8, do8, g8);
            else passes++;
        end
        rst = 1'b0;
        #1;
        checks++; if (r8 !== 8'h01) $display("FAIL first_rr_ready: got %b want 00000001", r8); else passes++;
        tick8();
        checks++;
        if ({vo8, do8, g8} !== {1'b1, 16'h1000, 3'd0})
            $display("FAIL first_rr_grant: got v=%b d=%h g=%0d want v=1 d=1000 g=0", vo8, do8, g8);
        else passes++;
    endtask

    task automatic test_fixed();
        mode8 = 1'b0; sel8 = 3'd5; v8 = '1; rdy8 = 1'b1;
        repeat (3) begin
            #1;
            checks++; if (r8 !== 8'h20) $display("FAIL fixed5_ready: got %b want 00100000", r8); else passes++;
            tick8();
            checks++;
            if ({vo8, do8, g8} !== {1'b1, 16'h1005, 3'd5})
                $display("FAIL fixed5_out: got v=%b d=%h g=%0d want v=1 d=1005 g=5", vo8, do8, g8);
            else passes++;
        end
        sel8 = 3'd7;
        #1;
        checks++; if (r8 !== 8'h80) $display("FAIL fixed7_ready: got %b want 10000000", r8); else passes++;
        tick8();
        checks++;
        if ({do8, g8} !== {16'h1007, 3'd7})
            $display("FAIL fixed7_out: got d=%h g=%0d want d=1007 g=7", do8, g8);
        else passes++;
    endtask

    task automatic test_rr_wrap();
        do_reset();
        mode8 = 1'b1; v8 = '1; rdy8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (r8 !== 8'(1 << (i % 8))) $display("FAIL rr_wrap_ready[%0d]: got %b", i, r8);
            else passes++;
            tick8();
            checks++;
            if ({vo8, g8, do8} !== {1'b1, 3'(i % 8), 16'(16'h1000 + i % 8)})
                $display("FAIL rr_wrap_grant[%0d]: got v=%b g=%0d d=%h want v=1 g=%0d",
                         i, vo8, g8, do8, i % 8);
            else passes++;
        end
    endtask

    task automatic test_rr_sparse();
        v8 = 8'b0100_0100;
        for (int i = 0; i < 4; i++) begin
            tick8();
            checks++;
            if (g8 !== ((i % 2 == 1) ? 3'd6 : 3'd2))
                $display("FAIL rr_sparse[%0d]: got %0d want %0d", i, g8, (i % 2 == 1) ? 6 : 2);
            else passes++;
        end
        v8 = 8'b0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick8();
            checks++;
            if ({vo8, g8} !== {1'b1, 3'd2}) $display("FAIL rr_single[%0d]: got v=%b g=%0d want v=1 g=2", i, vo8, g8);
            else passes++;
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] held_d;
        int          held_g;
        v8 = '1; mode8 = 1'b1; rdy8 = 1'b1;
        tick8();
        held_d = m8_d; held_g = m8_g;
        rdy8 = 1'b0;
        repeat (3) begin
            #1;
            checks++; if (r8 !== 8'h00) $display("FAIL stall_ready: got %b want 00000000", r8); else passes++;
            tick8();
            checks++;
            if ({vo8, do8, g8} !== {1'b1, held_d, 3'(held_g)})
                $display("FAIL stall_hold: got v=%b d=%h g=%0d want v=1 d=%h g=%0d",
                         vo8, do8, g8, held_d, held_g);
            else passes++;
        end
        rdy8 = 1'b1;
        #1;
        checks++;
        if (r8 !== 8'(1 << ((held_g + 1) % 8)))
            $display("FAIL release_ready: got %b want ch%0d", r8, (held_g + 1) % 8);
        else passes++;
        tick8();
        checks++;
        if ({vo8, g8} !== {1'b1, 3'((held_g + 1) % 8)})
            $display("FAIL release_load: got v=%b g=%0d want v=1 g=%0d", vo8, g8, (held_g + 1) % 8);
        else passes++;
    endtask

    task automatic test_random();
        logic [15:0] sbq [$];
        logic [7:0]  exp, rv;
        logic [15:0] dcur;
        bit          cons;
        do_reset();
        v8 = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 8; k++) begin
                if (!v8[k] && $urandom_range(0, 2) == 0) begin
                    v8[k] = 1'b1; ch8[k] = {4'(k), 12'(seq)}; seq++;
                end
            end
            mode8 = ($urandom_range(0, 3) != 0);
            sel8  = 3'($urandom_range(0, 7));
            rdy8  = ($urandom_range(0, 3) != 0);
            #1;
            exp = exp_rdy(8, v8, mode8, int'(sel8), p8, m8_v, rdy8);
            checks++; if (r8 !== exp) $display("FAIL rand_ready[%0d]: got %b want %b", cyc, r8, exp); else passes++;
            rv = r8; cons = vo8 && rdy8; dcur = do8;
            tick8();
            checks++;
            if ({vo8, g8} !== {m8_v, 3'(m8_g)} || (m8_v && do8 !== m8_d))
                $display("FAIL rand_out[%0d]: got v=%b d=%h g=%0d want v=%b d=%h g=%0d",
                         cyc, vo8, do8, g8, m8_v, m8_d, m8_g);
            else passes++;
            if (cons) begin
                checks++;
                if (sbq.size() == 0 || sbq[0] !== dcur)
                    $display("FAIL scoreboard[%0d]: got %h want %h", cyc, dcur,
                             (sbq.size() == 0) ? 16'hxxxx : sbq[0]);
                else passes++;
                if (sbq.size() != 0) void'(sbq.pop_front());
            end
            for (int k = 0; k < 8; k++) begin
                if (rv[k]) begin
                    sbq.push_back(ch8[k]);
                    v8[k] = 1'b0;
                end
            end
        end
        checks++;
        if (sbq.size() !== int'(vo8)) $display("FAIL scoreboard_end: got %0d beats want %0d", sbq.size(), int'(vo8));
        else passes++;
    endtask

    task automatic test_ways5();
        v8 = '0;
        do_reset();
        mode5 = 1'b1; v5 = '1; rdy5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (r5 !== 5'(1 << (i % 5))) $display("FAIL w5_ready[%0d]: got %b", i, r5); else passes++;
            tick5();
            checks++;
            if ({vo5, g5, do5} !== {1'b1, 3'(i % 5), 16'(16'h5000 + i % 5)})
                $display("FAIL w5_grant[%0d]: got v=%b g=%0d d=%h want g=%0d", i, vo5, g5, do5, i % 5);
            else passes++;
        end
        mode5 = 1'b0; sel5 = 3'd6; rdy5 = 1'b0;
        repeat (2) begin
            #1;
            checks++; if (r5 !== 5'b0) $display("FAIL w5_sel6_ready: got %b want 00000", r5); else passes++;
            tick5();
            checks++;
            if ({vo5, do5} !== {1'b1, 16'h5000}) $display("FAIL w5_hold: got v=%b d=%h want v=1 d=5000", vo5, do5);
            else passes++;
        end
        rdy5 = 1'b1;
        repeat (2) begin
            #1;
            checks++; if (r5 !== 5'b0) $display("FAIL w5_drain_ready: got %b want 00000", r5); else passes++;
            tick5();
            checks++;
            if ({vo5, do5, g5} !== {m5_v, 16'h5000, 3'd0} || m5_v)
                $display("FAIL w5_drain: got v=%b d=%h g=%0d want v=0 d=5000 g=0", vo5, do5, g5);
            else passes++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed();
        test_rr_wrap();
        test_rr_sparse();
        test_back_pressure();
        test_random();
        test_ways5();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
